// File: rtl/axi4lite_dmem_slave.sv
// AXI4-Lite slave wrapping a word-organised single-port SRAM for CPU data traffic.
// Independent write (AW/W -> commit -> B) and read (AR -> access -> R) engines share the array.
module axi4lite_dmem_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int                    IDX_W     = $clog2(MEM_DEPTH);
   localparam int                    STRB_W    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
   localparam logic [1:0]            RESP_OKAY   = 2'b00;
   localparam logic [1:0]            RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} rstate_t;

   wstate_t wstate, wstate_next;
   rstate_t rstate, rstate_next;

   logic                    aw_full, w_full, aw_full_next, w_full_next;
   logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [STRB_W-1:0]       w_strb;
   logic                    aw_hs, w_hs, ar_hs, rd_fire;
   logic [ADDR_WIDTH-1:0]   wr_off, rd_off;
   logic                    wr_ok, rd_ok;
   logic [IDX_W-1:0]        wr_idx, rd_idx;

   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   // Unsigned offset from the window base; addresses below BASE_ADDR are rejected explicitly
   assign wr_off = aw_addr - BASE_ADDR;
   assign rd_off = ar_addr - BASE_ADDR;
   assign wr_ok  = (aw_addr >= BASE_ADDR) && (wr_off < WIN_BYTES);
   assign rd_ok  = (ar_addr >= BASE_ADDR) && (rd_off < WIN_BYTES);
   assign wr_idx = wr_off[IDX_W+1:2];
   assign rd_idx = rd_off[IDX_W+1:2];

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // The write commit owns the single array port; a coinciding read waits one cycle
   assign rd_fire = (rstate == R_ACCESS) && (wstate != W_COMMIT);

   assign s_axi_bvalid = (wstate == W_RESP);
   assign s_axi_rvalid = (rstate == R_RESP);

   always_comb begin
      wstate_next  = wstate;
      aw_full_next = aw_full;
      w_full_next  = w_full;
      case (wstate)
         W_IDLE: begin
            aw_full_next = aw_full || aw_hs;
            w_full_next  = w_full || w_hs;
            if (aw_full_next && w_full_next)
               wstate_next = W_COMMIT;
         end
         W_COMMIT: wstate_next = W_RESP;
         W_RESP: begin
            if (s_axi_bready) begin
               wstate_next  = W_IDLE;
               aw_full_next = 1'b0;
               w_full_next  = 1'b0;
            end
         end
         default: begin
            wstate_next  = W_IDLE;
            aw_full_next = 1'b0;
            w_full_next  = 1'b0;
         end
      endcase
   end

   always_comb begin
      rstate_next = rstate;
      case (rstate)
         R_IDLE:   if (ar_hs) rstate_next = R_ACCESS;
         R_ACCESS: if (rd_fire) rstate_next = R_RESP;
         R_RESP:   if (s_axi_rready) rstate_next = R_IDLE;
         default:  rstate_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate        <= W_IDLE;
         rstate        <= R_IDLE;
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         aw_addr       <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         ar_addr       <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_arready <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rdata   <= '0;
      end else begin
         wstate  <= wstate_next;
         rstate  <= rstate_next;
         aw_full <= aw_full_next;
         w_full  <= w_full_next;
         if (aw_hs) aw_addr <= s_axi_awaddr;
         if (w_hs) begin
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
         end
         if (ar_hs) ar_addr <= s_axi_araddr;
         // Readies are registered from the next state so each one drops right after its handshake
         s_axi_awready <= (wstate_next == W_IDLE) && !aw_full_next;
         s_axi_wready  <= (wstate_next == W_IDLE) && !w_full_next;
         s_axi_arready <= (rstate_next == R_IDLE);
         if (wstate == W_COMMIT)
            s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (rd_fire) begin
            s_axi_rdata <= rd_ok ? mem[rd_idx] : '0;
            s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Array contents survive reset
   always_ff @(posedge clk) begin
      if (wstate == W_COMMIT && wr_ok) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_strb[i])
               mem[wr_idx][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

endmodule
